serial_adder: RTL and testbench

- Bit-serial N-bit adder, LSB first, one bit per clock, through a single full_adder cell and a carry flip-flop.
- It is the addition counterpart of the full_subtractor datapath.
- It sits beside the ALU as the low-area add path.
- It uses a start/busy/done handshake and holds its result registers until the next operation completes.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_full_adder.sv | 21 ++
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared state encoding and default width for the serial adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
// ============================================================================
// Module   : full_adder
// Purpose  : Single-bit combinational full adder used by the serial adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_adder (
  input  logic inbit_0,
  input  logic inbit_1,
  input  logic carry_in,
  output logic outbit_0,
  output logic carry_out
);

  assign outbit_0  = inbit_0 ^ inbit_1 ^ carry_in;
  assign carry_out = (inbit_0 & inbit_1) | (carry_in & (inbit_0 ^ inbit_1));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial LSB-first adder with start/busy/done handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] shift_a_q;
  logic [WIDTH-1:0] shift_b_q;
  logic [WIDTH-1:0] shift_s_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    count_q;
  logic             carry_q;
  logic             carry_msb_in_q;
  logic             busy_q;
  logic             done_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_accept;

  full_adder u_full_adder (
    .inbit_0   (shift_a_q[0]),
    .inbit_1   (shift_b_q[0]),
    .carry_in  (carry_q),
    .outbit_0  (w_fa_sum),
    .carry_out (w_fa_cout)
  );

  // DONE accepts a new start on the same edge that publishes the result.
  assign w_accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      shift_a_q      <= '0;
      shift_b_q      <= '0;
      shift_s_q      <= '0;
      sum_q          <= '0;
      count_q        <= '0;
      carry_q        <= 1'b0;
      carry_msb_in_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      carry_out_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          shift_a_q <= shift_a_q >> 1;
          shift_b_q <= shift_b_q >> 1;
          shift_s_q <= {w_fa_sum, shift_s_q[WIDTH-1:1]};
          carry_q   <= w_fa_cout;
          count_q   <= count_q + 1'b1;
          if (count_q == C_LAST_BIT) begin
            carry_msb_in_q <= carry_q;
            state_q        <= ST_DONE;
          end
        end
        ST_DONE: begin
          sum_q       <= shift_s_q;
          carry_out_q <= carry_q;
          overflow_q  <= carry_msb_in_q ^ carry_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (w_accept) begin
        shift_a_q <= operand_0;
        shift_b_q <= operand_1;
        carry_q   <= carry_in;
        count_q   <= '0;
        busy_q    <= 1'b1;
        state_q   <= ST_RUN;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Self-checking bench for serial_adder against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] operand_0;
  logic [WIDTH-1:0] operand_1;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .operand_0 (operand_0),
    .operand_1 (operand_1),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {overflow, carry_out, sum} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic c);
    int u;
    int sa;
    int sb;
    int s;
    logic [WIDTH:0] u_bits;
    logic ovf;
    u  = int'(a) + int'(b) + int'(c);
    sa = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
    sb = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
    s  = sa + sb + int'(c);
    ovf = (s > (1 << (WIDTH-1)) - 1) || (s < -(1 << (WIDTH-1)));
    u_bits = u[WIDTH:0];
    return {ovf, u_bits};
  endfunction

  // Issue one start and wait for done; lat counts cycles from the accept edge.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, output int lat);
    @(negedge clk);
    operand_0 = a; operand_1 = b; carry_in = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; operand_0 = '0; operand_1 = '0; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, sum, carry_out, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, need all 0",
               busy, done, sum, carry_out, overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] va [4] = '{8'h00, 8'hFF, 8'h7F, 8'h0F};
    logic [WIDTH-1:0] vb [4] = '{8'h00, 8'h01, 8'h01, 8'hF0};
    logic             vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [WIDTH+1:0] ex [4] = '{10'b0_0_00000000, 10'b0_1_00000000,
                                 10'b1_0_10000000, 10'b0_1_00000000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], lat);
      n_checks++;
      if (lat !== LAT) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, need %0d", i, lat, LAT);
      end
      n_checks++;
      if ({overflow, carry_out, sum} !== ex[i] ||
          {overflow, carry_out, sum} !== ref_add(va[i], vb[i], vc[i])) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got ovf=%b cout=%b sum=%h, need %b", i,
                 overflow, carry_out, sum, ex[i]);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_done_width[%0d]: got done=%b busy=%b, need 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_start_held;
    logic [WIDTH-1:0] a1, b1, a2, b2;
    logic c1, c2;
    int lat;
    a1 = 8'h3C; b1 = 8'h5A; c1 = 1'b1;
    a2 = 8'h81; b2 = 8'h92; c2 = 1'b0;
    @(negedge clk);
    operand_0 = a1; operand_1 = b1; carry_in = c1; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL held_run[%0d]: got done=%b busy=%b, need 0 1", k, done, busy);
      end
      operand_0 = WIDTH'($urandom); operand_1 = WIDTH'($urandom); carry_in = 1'($urandom);
    end
    @(negedge clk);
    operand_0 = a2; operand_1 = b2; carry_in = c2;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 ||
        {overflow, carry_out, sum} !== ref_add(a1, b1, c1)) begin
      n_fail++;
      $display("FAIL held_first: got done=%b busy=%b res=%b, need 1 1 %b",
               done, busy, {overflow, carry_out, sum}, ref_add(a1, b1, c1));
    end
    start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
    n_checks++;
    if (lat !== LAT || {overflow, carry_out, sum} !== ref_add(a2, b2, c2)) begin
      n_fail++;
      $display("FAIL held_second: got lat=%0d res=%b, need %0d %b",
               lat, {overflow, carry_out, sum}, LAT, ref_add(a2, b2, c2));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    @(negedge clk);
    operand_0 = 8'hA5; operand_1 = 8'h3B; carry_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, sum, carry_out, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, need all 0",
               busy, done, sum, carry_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (2 * LAT) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d active cycles, need 0", seen);
    end
    run_op(8'h44, 8'hCC, 1'b0, lat);
    n_checks++;
    if (lat !== LAT || {overflow, carry_out, sum} !== ref_add(8'h44, 8'hCC, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got lat=%0d res=%b, need %0d %b",
               lat, {overflow, carry_out, sum}, LAT, ref_add(8'h44, 8'hCC, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] qa [$];
    logic [WIDTH-1:0] qb [$];
    logic             qc [$];
    logic [WIDTH+1:0] exp_v;
    int issued, checked, gap, guard;
    @(negedge clk);
    operand_0 = WIDTH'($urandom); operand_1 = WIDTH'($urandom); carry_in = 1'($urandom);
    start = 1'b1;
    @(posedge clk);
    qa.push_back(operand_0); qb.push_back(operand_1); qc.push_back(carry_in);
    issued = 1; checked = 0; gap = 0; guard = 0;
    @(negedge clk);
    operand_0 = WIDTH'($urandom); operand_1 = WIDTH'($urandom); carry_in = 1'($urandom);
    while (checked < 100 && guard < 3000) begin
      if (done) begin
        exp_v = ref_add(qa.pop_front(), qb.pop_front(), qc.pop_front());
        n_checks++;
        if ({overflow, carry_out, sum} !== exp_v || gap !== LAT) begin
          n_fail++;
          $display("FAIL random[%0d]: got res=%b gap=%0d, need %b %0d",
                   checked, {overflow, carry_out, sum}, gap, exp_v, LAT);
        end
        checked++;
        gap = 0;
        if (issued < 100) begin
          qa.push_back(operand_0); qb.push_back(operand_1); qc.push_back(carry_in);
          issued++;
          if (issued == 100) start = 1'b0;
          operand_0 = WIDTH'($urandom); operand_1 = WIDTH'($urandom); carry_in = 1'($urandom);
        end
      end
      @(negedge clk);
      gap++;
      guard++;
    end
    start = 1'b0;
    n_checks++;
    if (checked !== 100) begin
      n_fail++;
      $display("FAIL random_count: got %0d results, need 100", checked);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
